gf2m_systolic_ctrl: RTL and testbench

Sequencing controller for the bit-parallel systolic GF(2^m) multiplier array. It accepts operands A and B through a valid/ready handshake and drives the array's shared control lines: load-select, the serial B bit, clock-enable and the field polynomial. It captures the product C after the array's output latency and returns it through a second valid/ready handshake. It sits between the operand source (e.g. a point-arithmetic sequencer) and the PE array.

---
 rtl/gf2m_systolic_ctrl_if.sv | 31 +++
 rtl/gf2m_systolic_ctrl.sv | 113 +++++++++++
 tb/tb_gf2m_systolic_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2m_systolic_ctrl_if.sv
// Operand, result and PE-array control signals of the systolic GF(2^m) multiplier controller.
// master: operand source, result consumer and array; slave: the controller itself.
interface gf2m_systolic_ctrl_if #(
    parameter int unsigned M = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a_in;
    logic [M-1:0] b_in;
    logic         abort;
    logic         arr_en;
    logic         arr_sel;
    logic [M-1:0] arr_a;
    logic [M-1:0] arr_f;
    logic         arr_b_bit;
    logic [M-1:0] arr_c;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] c_out;
    logic         busy;

    modport master (
        output in_valid, a_in, b_in, abort, out_ready, arr_c,
        input  in_ready, out_valid, c_out, busy, arr_en, arr_sel, arr_a, arr_f, arr_b_bit
    );

    modport slave (
        input  in_valid, a_in, b_in, abort, out_ready, arr_c,
        output in_ready, out_valid, c_out, busy, arr_en, arr_sel, arr_a, arr_f, arr_b_bit
    );
endinterface

// File: rtl/gf2m_systolic_ctrl.sv
// Sequencing controller for the bit-parallel systolic GF(2^m) multiplier: feeds B MSB first
// over M enabled cycles, waits out the array latency, then holds the product for the consumer.
module gf2m_systolic_ctrl #(
    parameter int unsigned  M       = 4,
    parameter logic [M-1:0] F_POLY  = M'(4'b0011),
    parameter int unsigned  ARR_LAT = 1
) (
    input logic             clk,
    input logic             reset,
    gf2m_systolic_ctrl_if.slave bus
);

    localparam int unsigned    KW    = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned    DW    = (ARR_LAT > 0) ? $clog2(ARR_LAT + 1) : 1;
    localparam logic [KW-1:0]  KLast = KW'(M - 1);
    localparam logic [DW-1:0]  DLast = DW'((ARR_LAT > 0) ? ARR_LAT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [DW-1:0]  d_q, d_d;
    logic [M-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic [M-1:0]   c_q, c_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            d_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            d_q     <= d_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        d_d     = d_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    k_d = '0;
                    if (ARR_LAT > 0) begin
                        d_d     = '0;
                        state_d = StDrain;
                    end else begin
                        c_d     = bus.arr_c;
                        state_d = StDone;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDrain: begin
                if (d_q == DLast) begin
                    d_d     = '0;
                    c_d     = bus.arr_c;
                    state_d = StDone;
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides everything, including an acceptance in IDLE; the last product is kept.
        if (bus.abort) begin
            state_d = StIdle;
            k_d     = '0;
            d_d     = '0;
            a_d     = a_q;
            b_d     = b_q;
            c_d     = c_q;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.busy      = (state_q != StIdle);
        bus.out_valid = (state_q == StDone);
        bus.arr_en    = (state_q == StRun);
        bus.arr_sel   = (state_q == StRun) && (k_q == '0);
        bus.arr_b_bit = (state_q == StRun) && b_q[KLast - k_q];
    end

    assign bus.arr_a = a_q;
    assign bus.arr_f = F_POLY;
    assign bus.c_out = c_q;

endmodule

// File: tb/tb_gf2m_systolic_ctrl.sv
// Directed bench for gf2m_systolic_ctrl: two instances (ARR_LAT=1 and ARR_LAT=0), each driving
// a behavioural MSB-first GF(2^4) array model with f(x)=x^4+x+1.
module tb_gf2m_systolic_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       abort;
    logic       out_ready;
    logic       use0;
    logic [3:0] a_in;
    logic [3:0] b_in;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    gf2m_systolic_ctrl_if #(.M(4)) bus1 ();
    gf2m_systolic_ctrl_if #(.M(4)) bus0 ();

    assign bus1.in_valid  = in_valid && !use0;
    assign bus1.abort     = abort && !use0;
    assign bus1.out_ready = out_ready && !use0;
    assign bus1.a_in      = a_in;
    assign bus1.b_in      = b_in;
    assign bus0.in_valid  = in_valid && use0;
    assign bus0.abort     = abort && use0;
    assign bus0.out_ready = out_ready && use0;
    assign bus0.a_in      = a_in;
    assign bus0.b_in      = b_in;

    gf2m_systolic_ctrl #(.M(4), .F_POLY(4'b0011), .ARR_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    gf2m_systolic_ctrl #(.M(4), .F_POLY(4'b0011), .ARR_LAT(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    // One array step: sel restarts the accumulator, otherwise multiply by x and reduce.
    function automatic logic [3:0] step(input logic [3:0] c, input logic [3:0] a,
                                        input logic [3:0] f, input logic sel, input logic b);
        logic [3:0] base;
        base = sel ? 4'h0 : ({c[2:0], 1'b0} ^ (c[3] ? f : 4'h0));
        return base ^ (b ? a : 4'h0);
    endfunction

    logic [3:0] acc1;
    logic [3:0] acc0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc1 <= 4'h0;
        else if (bus1.arr_en)
            acc1 <= step(acc1, bus1.arr_a, bus1.arr_f, bus1.arr_sel, bus1.arr_b_bit);
    end
    assign bus1.arr_c = acc1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc0 <= 4'h0;
        else if (bus0.arr_en)
            acc0 <= step(acc0, bus0.arr_a, bus0.arr_f, bus0.arr_sel, bus0.arr_b_bit);
    end
    assign bus0.arr_c = step(acc0, bus0.arr_a, bus0.arr_f, bus0.arr_sel, bus0.arr_b_bit);

    logic [3:0] o_in_ready, o_out_valid, o_busy, o_arr_en, o_arr_sel, o_b_bit, o_c_out, o_arr_a;
    assign o_in_ready  = {3'b0, use0 ? bus0.in_ready  : bus1.in_ready};
    assign o_out_valid = {3'b0, use0 ? bus0.out_valid : bus1.out_valid};
    assign o_busy      = {3'b0, use0 ? bus0.busy      : bus1.busy};
    assign o_arr_en    = {3'b0, use0 ? bus0.arr_en    : bus1.arr_en};
    assign o_arr_sel   = {3'b0, use0 ? bus0.arr_sel   : bus1.arr_sel};
    assign o_b_bit     = {3'b0, use0 ? bus0.arr_b_bit : bus1.arr_b_bit};
    assign o_c_out     = use0 ? bus0.c_out : bus1.c_out;
    assign o_arr_a     = use0 ? bus0.arr_a : bus1.arr_a;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction, sampled on falling edges; hold = extra cycles of out_ready=0 in DONE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp,
                          input int hold);
        int lat;
        lat = use0 ? 0 : 1;
        @(negedge clk);
        chk("idle_in_ready", o_in_ready, 4'd1);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = 4'h0;
        b_in     = 4'h0;
        chk("arr_a", o_arr_a, a);
        for (int i = 0; i < 4; i++) begin
            chk("run_en", o_arr_en, 4'd1);
            chk("run_sel", o_arr_sel, {3'b0, i == 0});
            chk("run_b_bit", o_b_bit, {3'b0, b[3-i]});
            chk("run_out_valid", o_out_valid, 4'd0);
            chk("run_in_ready", o_in_ready, 4'd0);
            @(negedge clk);
        end
        for (int i = 0; i < lat; i++) begin
            chk("drain_en", o_arr_en, 4'd0);
            chk("drain_b_bit", o_b_bit, 4'd0);
            chk("drain_out_valid", o_out_valid, 4'd0);
            chk("drain_busy", o_busy, 4'd1);
            @(negedge clk);
        end
        chk("done_valid", o_out_valid, 4'd1);
        chk("product", o_c_out, exp);
        chk("done_en", o_arr_en, 4'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", o_out_valid, 4'd1);
            chk("hold_c_out", o_c_out, exp);
            chk("hold_in_ready", o_in_ready, 4'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("back_in_ready", o_in_ready, 4'd1);
        chk("back_out_valid", o_out_valid, 4'd0);
        chk("back_c_out", o_c_out, exp);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        use0      = 1'b0;
        a_in      = 4'h0;
        b_in      = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", o_out_valid, 4'd0);
        chk("rst_busy", o_busy, 4'd0);
        chk("rst_arr_en", o_arr_en, 4'd0);
        chk("rst_c_out", o_c_out, 4'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", o_in_ready, 4'd1);

        // ARR_LAT=1 instance
        run_op(4'h3, 4'h5, 4'hF, 0);
        run_op(4'h8, 4'h2, 4'h3, 0);
        run_op(4'h7, 4'h7, 4'h6, 10);

        // Abort at RUN k=2
        in_valid = 1'b1;
        a_in     = 4'h3;
        b_in     = 4'h5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_k2_en", o_arr_en, 4'd1);
        chk("abort_k2_sel", o_arr_sel, 4'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", o_in_ready, 4'd1);
        chk("abort_arr_en", o_arr_en, 4'd0);
        chk("abort_busy", o_busy, 4'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", o_out_valid, 4'd0);
        end

        // Abort in IDLE blocks acceptance
        abort    = 1'b1;
        in_valid = 1'b1;
        a_in     = 4'h9;
        b_in     = 4'h9;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("idle_abort_busy", o_busy, 4'd0);
        chk("idle_abort_in_ready", o_in_ready, 4'd1);
        chk("idle_abort_arr_a", o_arr_a, 4'h3);
        run_op(4'h3, 4'h5, 4'hF, 0);

        // Asynchronous reset mid-DRAIN
        in_valid = 1'b1;
        a_in     = 4'h9;
        b_in     = 4'h6;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain_pre_busy", o_busy, 4'd1);
        chk("drain_pre_c_out", o_c_out, 4'hF);
        #2 reset = 1'b1;
        #1;
        chk("rst_drain_busy", o_busy, 4'd0);
        chk("rst_drain_arr_a", o_arr_a, 4'h0);
        chk("rst_drain_c_out", o_c_out, 4'h0);
        chk("rst_drain_out_valid", o_out_valid, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_drain_in_ready", o_in_ready, 4'd1);

        // Asynchronous reset mid-DONE
        in_valid = 1'b1;
        a_in     = 4'h3;
        b_in     = 4'h5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("done_pre_valid", o_out_valid, 4'd1);
        chk("done_pre_c_out", o_c_out, 4'hF);
        #2 reset = 1'b1;
        #1;
        chk("rst_done_out_valid", o_out_valid, 4'd0);
        chk("rst_done_c_out", o_c_out, 4'h0);
        chk("rst_done_busy", o_busy, 4'd0);
        chk("rst_done_arr_en", o_arr_en, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done_in_ready", o_in_ready, 4'd1);

        // ARR_LAT=0 instance
        use0 = 1'b1;
        run_op(4'h3, 4'h5, 4'hF, 0);
        run_op(4'h8, 4'h2, 4'h3, 2);
        run_op(4'h7, 4'h7, 4'h6, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
